// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data RAM responder with wait states and ready/err handshake
// Requests are latched in IDLE and acted on the following edge, so ready lands WAIT_CYCLES+1 edges after acceptance.
module data_mem_responder #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          ADDR_W   = $clog2(DEPTH);
  localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_lat;
  logic [31:0]         r_adr;
  logic [31:0]         r_wdata;
  logic                r_rd;
  logic                r_wr;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_err;
  logic                r_busy;
  logic [31:0]         r_mem [DEPTH];
  logic                w_illegal;
  logic                w_enter_resp;
  logic [ADDR_W-1:0]   w_idx;

  assign w_idx     = r_adr[ADDR_W+1:2];
  assign w_illegal = (r_adr[1:0] != 2'b00) || (r_adr >= LIMIT) || (r_rd && r_wr);

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE:  if (r_lat) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
    w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_lat   <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Only IDLE samples the bus; anything arriving while busy is dropped.
      if (r_state == S_IDLE) begin
        if (r_lat) begin
          r_lat <= 1'b0;
          r_cnt <= CNT_LOAD;
        end else if (MemRead || MemWrite) begin
          r_lat   <= 1'b1;
          r_adr   <= adr;
          r_wdata <= wdata;
          r_rd    <= MemRead;
          r_wr    <= MemWrite;
        end
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) r_rdata <= w_illegal ? 32'd0 : r_mem[w_idx];
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp && w_illegal;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // No reset on the array: contents survive reset, but a pending write is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && r_wr && !w_illegal) r_mem[w_idx] <= r_wdata;
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0;
  logic        err2, err0;
  logic        busy2, busy0;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .adr(adr), .wdata(wdata), .MemRead(mem_read), .MemWrite(mem_write),
    .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst), .adr(adr), .wdata(wdata), .MemRead(mem_read), .MemWrite(mem_write),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sel=1 observes the WAIT_CYCLES=2 instance, sel=0 the WAIT_CYCLES=0 instance.
  task automatic xfer(input string tag, input bit sel, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                      input bit exp_err, input bit chk_rd, input logic [31:0] exp_rd);
    int          lat;
    int          nbusy;
    logic        got_err;
    logic [31:0] got_rd;
    lat = -1; nbusy = 0; got_err = 1'b0; got_rd = '0;
    @(negedge clk);
    adr = a; wdata = d; mem_read = rd; mem_write = wr;
    @(posedge clk); #1;
    nbusy += int'(sel ? busy2 : busy0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      nbusy += int'(sel ? busy2 : busy0);
      if (sel ? ready2 : ready0) begin
        lat     = i;
        got_err = sel ? err2 : err0;
        got_rd  = sel ? rdata2 : rdata0;
        break;
      end
    end
    @(posedge clk); #1;
    nbusy += int'(sel ? busy2 : busy0);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      nbusy += int'(sel ? busy2 : busy0);
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    check_eq({tag, "_busy"}, 32'(nbusy), 32'(exp_lat));
    if (chk_rd) check_eq({tag, "_rdata"}, got_rd, exp_rd);
  endtask

  initial begin
    int nready;
    rst = 1'b0; adr = '0; wdata = '0; mem_read = 1'b1; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, ready2}, 32'd0);
    check_eq("rst_err",   {31'd0, err2},   32'd0);
    check_eq("rst_busy",  {31'd0, busy2},  32'd0);
    check_eq("rst_rdata", rdata2,          32'd0);
    check_eq("rst_busy0", {31'd0, busy0},  32'd0);
    mem_read = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);

    xfer("wr10",   1, 0, 1, 32'h10,  32'hDEADBEEF, 3, 0, 0, 32'h0);
    xfer("rd10",   1, 1, 0, 32'h10,  32'h0,        3, 0, 1, 32'hDEADBEEF);
    xfer("mis12",  1, 1, 0, 32'h12,  32'h0,        3, 1, 1, 32'h0);
    xfer("rd10b",  1, 1, 0, 32'h10,  32'h0,        3, 0, 1, 32'hDEADBEEF);

    xfer("wr3fc",  1, 0, 1, 32'h3FC, 32'hCAFEF00D, 3, 0, 0, 32'h0);
    xfer("wr0",    1, 0, 1, 32'h0,   32'h11111111, 3, 0, 0, 32'h0);
    xfer("oor400", 1, 0, 1, 32'h400, 32'h1,        3, 1, 0, 32'h0);
    xfer("rd3fc",  1, 1, 0, 32'h3FC, 32'h0,        3, 0, 1, 32'hCAFEF00D);
    xfer("rd0",    1, 1, 0, 32'h0,   32'h0,        3, 0, 1, 32'h11111111);

    xfer("wr20",   1, 0, 1, 32'h20,  32'h12345678, 3, 0, 0, 32'h0);
    xfer("rw20",   1, 1, 1, 32'h20,  32'hFFFFFFFF, 3, 1, 1, 32'h0);
    xfer("rw20_w0",0, 1, 1, 32'h20,  32'hFFFFFFFF, 1, 1, 1, 32'h0);
    xfer("rd20",   1, 1, 0, 32'h20,  32'h0,        3, 0, 1, 32'h12345678);

    xfer("wr8",    1, 0, 1, 32'h8,   32'hA5A5A5A5, 3, 0, 0, 32'h0);
    nready = 0;
    @(negedge clk);
    adr = 32'h8; wdata = 32'h55; mem_write = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nready += int'(ready2);
    mem_write = 1'b0;
    @(posedge clk); #1;
    nready += int'(ready2);
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      nready += int'(ready2);
    end
    check_eq("midrst_noready", 32'(nready), 32'd0);
    check_eq("midrst_busy", {31'd0, busy2}, 32'd0);
    xfer("rd8",    1, 1, 0, 32'h8,   32'h0,        3, 0, 1, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
